neuronal_pipes: RTL and testbench
=================================

// Module: neuronal_pipes
// PURPOSE
// - One Euler step (dt = 1 ms) of an Izhikevich spiking neuron in signed fixed point.
// - Per enabled clock: takes state (v, u) and input current I; registers next state and spike flag.
// - Sits in the neuron-update datapath. The caller feeds v_out/u_out back to v_in/u_in for closed-loop
//   simulation, or time-multiplexes many neurons through the block.
// PARAMETERS
// - WIDTH    32        total bits of every signed fixed-point word
// - FRAC     16        fractional bits (Q(WIDTH-FRAC).FRAC, two's complement)
// - A_FX     1311      recovery rate a = 0.02, scaled by 2^FRAC
// - B_FX     13107     sensitivity b = 0.2, scaled
// - C_FX     -4259840  reset potential c = -65.0 mV, scaled
// - D_FX     524288    recovery jump d = 8.0, scaled
// - K1_FX    2621      quadratic coefficient 0.04, scaled
// - K2_FX    327680    linear coefficient 5.0, scaled
// - K3_FX    9175040   constant 140.0, scaled
// - VPEAK_FX 1966080   spike threshold 30.0 mV, scaled
// - Scaled defaults are valid for FRAC = 16; the integrator overrides them together with FRAC.
// PORTS
// - clk        in   1      clock; all state changes on its rising edge
// - rst        in   1      asynchronous, active-high reset
// - en         in   1      step enable; when 0, outputs hold
// - v_in       in   WIDTH  membrane potential v (signed, mV)
// - u_in       in   WIDTH  recovery variable u (signed)
// - I_in       in   WIDTH  input current I (signed)
// - v_out      out  WIDTH  registered next v
// - u_out      out  WIDTH  registered next u
// - spike_out  out  1      registered; 1 for exactly the step in which a spike fired
// BEHAVIOUR
// - Reset (async, rst=1): v_out=C_FX, u_out=0, spike_out=0. Release takes effect at the next edge.
// - Latency: 1 cycle. Inputs sampled at rising edge with en=1 give results at that same edge.
// - Arithmetic is combinational. Each product is formed at 2*WIDTH bits, then arithmetic-shifted
//   right by FRAC (floor).
//   - v2  = (v*v)>>>FRAC
//   - dv  = (K1*v2)>>>FRAC + (K2*v)>>>FRAC + K3 - u + I
//   - vn  = v + dv
//   - bv  = (B*v)>>>FRAC
//   - un  = u + (A*(bv-u))>>>FRAC
// - All sums are kept at 2*WIDTH bits. vn and un saturate to the signed WIDTH range
//   [-2^(WIDTH-1), 2^(WIDTH-1)-1]; the intermediate v2 saturates likewise. No wrap-around is allowed.
// - Spike: if vn >= VPEAK_FX (signed compare, after saturation), then v_out=C_FX,
//   u_out=sat(un+D_FX), spike_out=1.
// - No spike: v_out=vn, u_out=un, spike_out=0.
// - en=0: v_out, u_out and spike_out hold their previous values. spike_out does not re-pulse.
// - Stateless apart from the output registers. There is no refractory period and no internal
//   history, so consecutive steps may each spike.
// - rst mid-operation overrides en and any in-flight step immediately.
// TESTING
// - Reset: hold rst 5 cycles -> v_out=-4259840, u_out=0, spike_out=0. Outputs unchanged while en=0
//   after release.
// - Rest step: v_in=-65.0, u_in=0, I_in=0, en=1 -> one cycle later v_out ~ -81.0 and u_out ~ -0.26
//   (within +/-0.01 of the real model), spike_out=0.
// - Exact spike: v_in=0, u_in=0, I_in=0 -> vn=140.0 >= 30, giving v_out=-4259840, u_out=524288 (8.0),
//   spike_out=1. Next step with v_in=-65.0 clears spike_out.
// - Enable hold: apply the exact-spike stimulus with en=0 -> outputs keep their prior values;
//   assert en=1 -> update on that edge.
// - Saturation: v_in=2^(WIDTH-1)-1, u_in=0, I_in=0 -> no wrap; treated as spike, giving
//   v_out=C_FX and spike_out=1. Also v_in=-2^(WIDTH-1) -> v_out is a valid saturated value.
// - Closed loop: v_in<=v_out, u_in<=u_out each cycle, I_in=10.0 for 200 steps from (-65, 0):
//   - regular tonic spiking (>=3 spikes)
//   - v_out never exceeds VPEAK_FX
//   - every spike_out=1 coincides with v_out=C_FX
//   - u_out steps up by ~8.0 at each spike

Source files
------------

// File: rtl/neuronal_pipes.sv
// neuronal_pipes: one 1 ms Euler step of an Izhikevich neuron in signed fixed point.
// All arithmetic is combinational at 2*WIDTH bits. Only v_out, u_out and spike_out are registered.
module neuronal_pipes #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter logic signed [WIDTH-1:0] A_FX     = 1311,
    parameter logic signed [WIDTH-1:0] B_FX     = 13107,
    parameter logic signed [WIDTH-1:0] C_FX     = -4259840,
    parameter logic signed [WIDTH-1:0] D_FX     = 524288,
    parameter logic signed [WIDTH-1:0] K1_FX    = 2621,
    parameter logic signed [WIDTH-1:0] K2_FX    = 327680,
    parameter logic signed [WIDTH-1:0] K3_FX    = 9175040,
    parameter logic signed [WIDTH-1:0] VPEAK_FX = 1966080
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] u_in,
    input  logic signed [WIDTH-1:0] I_in,
    output logic signed [WIDTH-1:0] v_out,
    output logic signed [WIDTH-1:0] u_out,
    output logic                    spike_out
);

    localparam int W2 = 2 * WIDTH;

    // Signed WIDTH range expressed at double width, used as saturation bounds.
    localparam logic signed [W2-1:0] SAT_MAX = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [W2-1:0] SAT_MIN = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Coefficients sign-extended once so every product is formed at 2*WIDTH bits.
    localparam logic signed [W2-1:0] A_X  = {{WIDTH{A_FX[WIDTH-1]}}, A_FX};
    localparam logic signed [W2-1:0] B_X  = {{WIDTH{B_FX[WIDTH-1]}}, B_FX};
    localparam logic signed [W2-1:0] D_X  = {{WIDTH{D_FX[WIDTH-1]}}, D_FX};
    localparam logic signed [W2-1:0] K1_X = {{WIDTH{K1_FX[WIDTH-1]}}, K1_FX};
    localparam logic signed [W2-1:0] K2_X = {{WIDTH{K2_FX[WIDTH-1]}}, K2_FX};
    localparam logic signed [W2-1:0] K3_X = {{WIDTH{K3_FX[WIDTH-1]}}, K3_FX};

    function automatic logic signed [W2-1:0] sx(input logic signed [WIDTH-1:0] x);
        sx = {{WIDTH{x[WIDTH-1]}}, x};
    endfunction

    // Clamp a double-width value into the signed WIDTH range (never wraps).
    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [W2-1:0] x);
        if (x > SAT_MAX) begin
            sat_w = SAT_MAX[WIDTH-1:0];
        end else if (x < SAT_MIN) begin
            sat_w = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_w = x[WIDTH-1:0];
        end
    endfunction

    logic signed [W2-1:0]    v_x, u_x, i_x;
    logic signed [W2-1:0]    v2_full;
    logic signed [WIDTH-1:0] v2;
    logic signed [W2-1:0]    quad_term, lin_term;
    logic signed [W2-1:0]    vn_full;
    logic signed [WIDTH-1:0] vn;
    logic signed [W2-1:0]    bv, rec_term, un_full;
    logic signed [WIDTH-1:0] un;
    logic signed [WIDTH-1:0] u_jump;
    logic                    fire;

    logic signed [WIDTH-1:0] v_next, u_next;

    // Euler step datapath: dv = 0.04 v^2 + 5 v + 140 - u + I ; du = a (b v - u).
    always_comb begin
        v_x       = sx(v_in);
        u_x       = sx(u_in);
        i_x       = sx(I_in);

        // v^2 can exceed the WIDTH range for large |v|; clamp before reuse.
        v2_full   = (v_x * v_x) >>> FRAC;
        v2        = sat_w(v2_full);

        quad_term = (K1_X * sx(v2)) >>> FRAC;
        lin_term  = (K2_X * v_x) >>> FRAC;
        vn_full   = v_x + quad_term + lin_term + K3_X - u_x + i_x;
        vn        = sat_w(vn_full);

        bv        = (B_X * v_x) >>> FRAC;
        rec_term  = (A_X * (bv - u_x)) >>> FRAC;
        un_full   = u_x + rec_term;
        un        = sat_w(un_full);

        // Recovery jump applied to the already-clamped un, then clamped again.
        u_jump    = sat_w(sx(un) + D_X);

        // Threshold is checked on the saturated potential, so overflow reads as a spike.
        fire      = (vn >= VPEAK_FX);
    end

    // Spike handling: a firing step resets v to c and bumps u by d.
    always_comb begin
        v_next = vn;
        u_next = un;
        if (fire) begin
            v_next = C_FX;
            u_next = u_jump;
        end
    end

    // Output registers: async reset to rest potential, update only on enabled steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out     <= C_FX;
            u_out     <= '0;
            spike_out <= 1'b0;
        end else if (en) begin
            v_out     <= v_next;
            u_out     <= u_next;
            spike_out <= fire;
        end
    end

endmodule

// File: tb/tb_neuronal_pipes.sv
// Testbench for neuronal_pipes: directed steps with a scoreboard queue fed by a longint reference model.
module tb_neuronal_pipes;

    localparam longint FRAC  = 16;
    localparam longint A     = 1311;
    localparam longint B     = 13107;
    localparam longint C     = -4259840;
    localparam longint D     = 524288;
    localparam longint K1    = 2621;
    localparam longint K2    = 327680;
    localparam longint K3    = 9175040;
    localparam longint VPEAK = 1966080;
    localparam longint MAXV  = 64'sd2147483647;
    localparam longint MINV  = -64'sd2147483648;
    localparam longint REST_V = -4259840;
    localparam longint I_TEN  = 655360;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [31:0] v_in, u_in, I_in;
    logic signed [31:0] v_out, u_out;
    logic               spike_out;

    neuronal_pipes dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .v_in      (v_in),
        .u_in      (u_in),
        .I_in      (I_in),
        .v_out     (v_out),
        .u_out     (u_out),
        .spike_out (spike_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string              tag;
        logic signed [31:0] v;
        logic signed [31:0] u;
        logic               s;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Expected register contents tracked by the bench
    longint ev = C;
    longint eu = 0;
    logic   es = 1'b0;

    function automatic longint clamp(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    // Real-number Izhikevich step expressed in integer fixed point (floor shifts, clamps).
    function automatic void model(input longint v, input longint u, input longint i,
                                  output longint vo, output longint uo, output logic sp);
        longint v2, vn, bv, un;
        v2 = clamp((v * v) >>> FRAC);
        vn = clamp(v + ((K1 * v2) >>> FRAC) + ((K2 * v) >>> FRAC) + K3 - u + i);
        bv = (B * v) >>> FRAC;
        un = clamp(u + ((A * (bv - u)) >>> FRAC));
        if (vn >= VPEAK) begin
            vo = C;
            uo = clamp(un + D);
            sp = 1'b1;
        end else begin
            vo = vn;
            uo = un;
            sp = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.v   = ev[31:0];
        e.u   = eu[31:0];
        e.s   = es;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0d entries expected 1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_v"}, v_out, e.v);
            chk({e.tag, "_u"}, u_out, e.u);
            chk_bit({e.tag, "_spike"}, spike_out, e.s);
        end
    endtask

    // Drive one step just after an edge, push the expectation, compare just after the next edge.
    task automatic do_step(input logic e, input longint v, input longint u, input longint i,
                           input string tag);
        longint vo, uo;
        logic   sp;
        en   = e;
        v_in = v[31:0];
        u_in = u[31:0];
        I_in = i[31:0];
        if (e) begin
            model(v, u, i, vo, uo, sp);
            ev = vo;
            eu = uo;
            es = sp;
        end
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected summary before 2000000");
        $fatal(1);
    end

    initial begin
        longint cv, cu, pu;
        int     spikes;

        rst  = 1'b1;
        en   = 1'b0;
        v_in = '0;
        u_in = '0;
        I_in = '0;

        repeat (5) @(posedge clk);
        #1;
        ev = C; eu = 0; es = 1'b0;
        push_exp("reset");
        pop_check();
        rst = 1'b0;

        do_step(1'b0, 0, 0, 0, "hold_after_rst_a");
        do_step(1'b0, 12345, 678, 9, "hold_after_rst_b");

        do_step(1'b1, REST_V, 0, 0, "rest");
        chk("rest_v_const", v_out, -32'sd5310275);
        chk("rest_u_const", u_out, -32'sd17043);

        do_step(1'b1, 0, 0, 0, "exact_spike");
        chk("exact_spike_v_const", v_out, -32'sd4259840);
        chk("exact_spike_u_const", u_out, 32'sd524288);
        chk_bit("exact_spike_s_const", spike_out, 1'b1);

        do_step(1'b1, REST_V, 0, 0, "spike_clear");
        chk_bit("spike_clear_const", spike_out, 1'b0);

        do_step(1'b0, 0, 0, 0, "en_hold");
        chk("en_hold_v_const", v_out, -32'sd5310275);
        do_step(1'b1, 0, 0, 0, "en_go");

        do_step(1'b1, MAXV, 0, 0, "sat_pos");
        chk("sat_pos_v_const", v_out, -32'sd4259840);
        chk_bit("sat_pos_s_const", spike_out, 1'b1);

        do_step(1'b1, MINV, 0, 0, "sat_neg");
        chk("sat_neg_v_const", v_out, -32'sd2147483648);
        chk("sat_neg_u_const", u_out, -32'sd8591639);

        do_step(1'b1, 0, 0, 0, "b2b_first");
        do_step(1'b1, 0, 65536, 0, "b2b_second");

        do_step(1'b1, -3276800, 131072, 327680, "misc_a");
        do_step(1'b1, 983040, -262144, -655360, "misc_b");

        // Asynchronous reset in the middle of a cycle with en=1
        en   = 1'b1;
        v_in = 32'sd0;
        u_in = 32'sd0;
        I_in = 32'sd0;
        #3;
        rst = 1'b1;
        #1;
        ev = C; eu = 0; es = 1'b0;
        push_exp("mid_reset");
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Closed loop with I = 10.0 from rest
        cv = C;
        cu = 0;
        spikes = 0;
        for (int k = 0; k < 200; k++) begin
            pu = cu;
            do_step(1'b1, cv, cu, I_TEN, "loop");
            cv = ev;
            cu = eu;
            n_cmp++;
            assert (v_out <= 32'sd1966080) else begin
                n_bad++;
                $error("FAIL loop_vpeak: observed %0d expected <= %0d", v_out, VPEAK);
            end
            if (spike_out) begin
                spikes++;
                chk("loop_spike_v", v_out, -32'sd4259840);
                n_cmp++;
                assert ((longint'(u_out) - pu >= D - 32768) && (longint'(u_out) - pu <= D + 32768)) else begin
                    n_bad++;
                    $error("FAIL loop_u_jump: observed %0d expected %0d +/- 32768",
                           longint'(u_out) - pu, D);
                end
            end
        end
        n_cmp++;
        assert (spikes >= 3) else begin
            n_bad++;
            $error("FAIL loop_spike_count: observed %0d expected >= 3", spikes);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
